dice_lights_gen: RTL

Parametrised successor to the dice/traffic-light selector. Two independent sequential engines share one 3-bit result bus, chosen by sel:
- an N-faced electronic die driven by a push button;
- a four-phase traffic-light sequencer with a configurable dwell time per phase.

The block sits between the board button/select inputs and the 3-LED output stage. It adds a registered roll-complete pulse that the previous generation lacked.

---
 rtl/dotl_pkg.sv | 18 +
 rtl/light_seq.sv | 75 +++++++
 rtl/dice_lights_gen.sv | 68 ++++++
 3 files changed

// File: rtl/dotl_pkg.sv
// Shared types and constants for the dice / traffic-light generator.
package dotl_pkg;

    typedef enum logic [1:0] {
        RED       = 2'd0,
        RED_AMBER = 2'd1,
        GREEN     = 2'd2,
        AMBER     = 2'd3
    } light_state_t;

    localparam logic [2:0] CODE_RED       = 3'b100;
    localparam logic [2:0] CODE_RED_AMBER = 3'b110;
    localparam logic [2:0] CODE_GREEN     = 3'b001;
    localparam logic [2:0] CODE_AMBER     = 3'b010;

    localparam logic [2:0] DIE_RESET      = 3'b001;

endpackage

// File: rtl/light_seq.sv
// Four-phase traffic-light sequencer with per-phase dwell counter.
//   state     | meaning
//   RED       | stop, held RED_TICKS cycles
//   RED_AMBER | prepare to go, held RED_AMBER_TICKS cycles
//   GREEN     | go, held GREEN_TICKS cycles
//   AMBER     | prepare to stop, held AMBER_TICKS cycles
module light_seq
    import dotl_pkg::*;
#(
    parameter int unsigned RED_TICKS       = 4,
    parameter int unsigned RED_AMBER_TICKS = 1,
    parameter int unsigned GREEN_TICKS     = 4,
    parameter int unsigned AMBER_TICKS     = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] code
);

    localparam logic [7:0] RED_LAST       = 8'(RED_TICKS - 1);
    localparam logic [7:0] RED_AMBER_LAST = 8'(RED_AMBER_TICKS - 1);
    localparam logic [7:0] GREEN_LAST     = 8'(GREEN_TICKS - 1);
    localparam logic [7:0] AMBER_LAST     = 8'(AMBER_TICKS - 1);

    light_state_t state;
    logic [7:0]   dwell;
    logic [7:0]   last;

    always_comb begin
        last = RED_LAST;
        case (state)
            RED:       last = RED_LAST;
            RED_AMBER: last = RED_AMBER_LAST;
            GREEN:     last = GREEN_LAST;
            AMBER:     last = AMBER_LAST;
            default:   last = RED_LAST;
        endcase
    end

    // Advance on the terminal count; >= also pulls a corrupted count back in range.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RED;
            dwell <= 8'd0;
            code  <= CODE_RED;
        end else if (dwell >= last) begin
            dwell <= 8'd0;
            case (state)
                RED: begin
                    state <= RED_AMBER;
                    code  <= CODE_RED_AMBER;
                end
                RED_AMBER: begin
                    state <= GREEN;
                    code  <= CODE_GREEN;
                end
                GREEN: begin
                    state <= AMBER;
                    code  <= CODE_AMBER;
                end
                AMBER: begin
                    state <= RED;
                    code  <= CODE_RED;
                end
                default: begin
                    state <= RED;
                    code  <= CODE_RED;
                end
            endcase
        end else begin
            dwell <= dwell + 8'd1;
        end
    end

endmodule

// File: rtl/dice_lights_gen.sv
// N-faced die and traffic-light sequencer sharing one 3-bit result bus,
// plus a registered roll-complete pulse on button release.
module dice_lights_gen
    import dotl_pkg::*;
#(
    parameter int unsigned DICE_MAX        = 6,
    parameter int unsigned RED_TICKS       = 4,
    parameter int unsigned RED_AMBER_TICKS = 1,
    parameter int unsigned GREEN_TICKS     = 4,
    parameter int unsigned AMBER_TICKS     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic       sel,
    output logic [2:0] result,
    output logic       roll_done
);

    generate
        if (DICE_MAX < 2 || DICE_MAX > 7) begin : g_bad_dice_max
            $error("dice_lights_gen: DICE_MAX must be in 2..7");
        end
        if (RED_TICKS < 1 || RED_TICKS > 255 ||
            RED_AMBER_TICKS < 1 || RED_AMBER_TICKS > 255 ||
            GREEN_TICKS < 1 || GREEN_TICKS > 255 ||
            AMBER_TICKS < 1 || AMBER_TICKS > 255) begin : g_bad_ticks
            $error("dice_lights_gen: phase tick counts must be in 1..255");
        end
    endgenerate

    localparam logic [2:0] DIE_MAX = 3'(DICE_MAX);

    logic [2:0] die;
    logic       button_q;
    logic [2:0] light_code;

    light_seq #(
        .RED_TICKS       (RED_TICKS),
        .RED_AMBER_TICKS (RED_AMBER_TICKS),
        .GREEN_TICKS     (GREEN_TICKS),
        .AMBER_TICKS     (AMBER_TICKS)
    ) u_light_seq (
        .clk  (clk),
        .rst  (rst),
        .code (light_code)
    );

    // Out-of-range faces snap back to 1 regardless of the button.
    always_ff @(posedge clk) begin
        if (rst) begin
            die       <= DIE_RESET;
            button_q  <= 1'b0;
            roll_done <= 1'b0;
        end else begin
            button_q  <= button;
            roll_done <= button_q & ~button;
            if (die == 3'd0 || die > DIE_MAX) begin
                die <= DIE_RESET;
            end else if (button) begin
                die <= (die == DIE_MAX) ? DIE_RESET : die + 3'd1;
            end
        end
    end

    assign result = sel ? light_code : die;

endmodule
